// File: rtl/bullet_pkg.sv
// Shared types for the player bullet pool.
// Coordinates are screen pixels; a slot record is one bullet.
package bullet_pkg;
  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } slot_t;
endpackage

// File: rtl/reimu_bullet_pool_if.sv
// Game-side bundle for the bullet pool: player/boss inputs,
// packed bullet positions and hit outputs.
interface reimu_bullet_pool_if #(
  parameter int N_BULLETS = 4,
  parameter int CNT_W     = 8
);
  import bullet_pkg::*;

  logic                           tick;
  logic                           enable;
  logic                           fire;
  coord_t                         reimux;
  coord_t                         reimuy;
  coord_t                         bossx;
  coord_t                         bossy;
  logic                           boss_vuln;
  logic [COORD_W*N_BULLETS-1:0]   bullet_x;
  logic [COORD_W*N_BULLETS-1:0]   bullet_y;
  logic [N_BULLETS-1:0]           bullet_valid;
  logic                           pool_full;
  logic                           hit_pulse;
  logic [CNT_W-1:0]               hit_count;

  modport master (
    output tick, enable, fire,
    output reimux, reimuy, bossx, bossy, boss_vuln,
    input  bullet_x, bullet_y, bullet_valid,
    input  pool_full, hit_pulse, hit_count
  );

  modport slave (
    input  tick, enable, fire,
    input  reimux, reimuy, bossx, bossy, boss_vuln,
    output bullet_x, bullet_y, bullet_valid,
    output pool_full, hit_pulse, hit_count
  );
endinterface

// File: rtl/bullet_slot.sv
// One bullet: moves up per tick, retires at screen top or on
// boss contact; loads a fresh bullet only when it was free.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int STEP    = 8,
  parameter int BOSS_HW = 32,
  parameter int BOSS_HH = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  logic   tick,
  input  logic   boss_vuln,
  input  coord_t bossx,
  input  coord_t bossy,
  input  logic   load,
  input  coord_t load_x,
  input  coord_t load_y,
  output logic   hit,
  output logic   free,
  output slot_t  slot
);
  localparam int DW = COORD_W + 1;

  slot_t slot_q, slot_d;
  coord_t ny;
  logic exit_top, in_box;
  logic signed [DW-1:0] dx, dy;
  logic [DW-1:0] adx, ady;

  always_comb begin
    ny       = slot_q.y - COORD_W'(STEP);
    exit_top = slot_q.y < COORD_W'(STEP);
    dx  = $signed({1'b0, slot_q.x}) - $signed({1'b0, bossx});
    dy  = $signed({1'b0, ny}) - $signed({1'b0, bossy});
    adx = dx[DW-1] ? -dx : dx;
    ady = dy[DW-1] ? -dy : dy;
    in_box = boss_vuln
          && (adx < DW'(BOSS_HW))
          && (ady < DW'(BOSS_HH));
    hit = enable && tick && slot_q.valid
       && !exit_top && in_box;

    // Retired slots zero x/y so the renderer sees 0 for free slots
    slot_d = slot_q;
    if (!enable) begin
      slot_d = '0;
    end else if (tick) begin
      if (slot_q.valid) begin
        if (exit_top || in_box) slot_d = '0;
        else                    slot_d.y = ny;
      end else if (load) begin
        slot_d = '{valid: 1'b1, x: load_x, y: load_y};
      end
    end
  end

  assign free = !slot_q.valid;
  assign slot = slot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slot_q <= '0;
    else      slot_q <= slot_d;
  end
endmodule

// File: rtl/reimu_bullet_pool.sv
// Pool of player bullets: lowest-free spawn with cooldown,
// saturating hit counter and packed outputs for the renderer.
module reimu_bullet_pool
  import bullet_pkg::*;
#(
  parameter int N_BULLETS  = 4,
  parameter int STEP       = 8,
  parameter int COOLDOWN   = 3,
  parameter int SPAWN_YOFF = 16,
  parameter int BOSS_HW    = 32,
  parameter int BOSS_HH    = 32,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic rst,
  reimu_bullet_pool_if.slave bus
);
  localparam int CD_W  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam int PC_W  = $clog2(N_BULLETS + 1);
  localparam int SUM_W = CNT_W + PC_W;

  logic [N_BULLETS-1:0] free, hits, load, valid;
  slot_t slots [N_BULLETS];
  coord_t spawn_y;
  logic spawn;

  logic [CD_W-1:0]  cd_q, cd_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [PC_W-1:0]  n_hits;
  logic [SUM_W-1:0] sum;

  for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_slot
    bullet_slot #(
      .STEP    (STEP),
      .BOSS_HW (BOSS_HW),
      .BOSS_HH (BOSS_HH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .enable    (bus.enable),
      .tick      (bus.tick),
      .boss_vuln (bus.boss_vuln),
      .bossx     (bus.bossx),
      .bossy     (bus.bossy),
      .load      (load[gi]),
      .load_x    (bus.reimux),
      .load_y    (spawn_y),
      .hit       (hits[gi]),
      .free      (free[gi]),
      .slot      (slots[gi])
    );
  end

  always_comb begin
    spawn = bus.enable && bus.tick && bus.fire
         && (cd_q == '0) && (|free);
    // Downward scan: the lowest free index wins
    load = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (spawn && free[i]) begin
        load    = '0;
        load[i] = 1'b1;
      end
    end
    spawn_y = (bus.reimuy >= COORD_W'(SPAWN_YOFF))
            ? bus.reimuy - COORD_W'(SPAWN_YOFF)
            : '0;
  end

  always_comb begin
    cd_d = cd_q;
    if (!bus.enable)      cd_d = '0;
    else if (bus.tick) begin
      if (cd_q != '0)     cd_d = cd_q - CD_W'(1);
      else if (spawn)     cd_d = CD_W'(COOLDOWN);
    end
  end

  always_comb begin
    n_hits = '0;
    for (int i = 0; i < N_BULLETS; i++)
      n_hits = n_hits + PC_W'(hits[i]);
    sum = SUM_W'(hit_count_q) + SUM_W'(n_hits);
    hit_count_d = (sum > SUM_W'({CNT_W{1'b1}}))
                ? '1 : sum[CNT_W-1:0];
    hit_pulse_d = |hits;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_q        <= '0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      cd_q        <= cd_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
    end
  end

  always_comb begin
    bus.bullet_x = '0;
    bus.bullet_y = '0;
    valid        = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      bus.bullet_x[COORD_W*i +: COORD_W] = slots[i].x;
      bus.bullet_y[COORD_W*i +: COORD_W] = slots[i].y;
      valid[i] = slots[i].valid;
    end
  end

  assign bus.bullet_valid = valid;
  assign bus.pool_full    = &valid;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.hit_count    = hit_count_q;
endmodule

// File: tb/tb_reimu_bullet_pool.sv
// Directed bench for the bullet pool: spawn, cooldown, hits,
// top exit, slot reuse, enable clear and async reset.
module tb_reimu_bullet_pool;
  logic clk;
  logic rst;
  int n_chk;
  int n_pass;

  reimu_bullet_pool_if #(.N_BULLETS(4), .CNT_W(8)) bus ();

  reimu_bullet_pool #(
    .N_BULLETS  (4),
    .STEP       (8),
    .COOLDOWN   (3),
    .SPAWN_YOFF (16),
    .BOSS_HW    (32),
    .BOSS_HH    (32),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic step(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic clear_pool();
    bus.fire   = 1'b0;
    bus.enable = 1'b0;
    step(1'b0);
    bus.enable = 1'b1;
  endtask

  function automatic logic [63:0] vld();
    return 64'(bus.bullet_valid);
  endfunction

  function automatic logic [63:0] xv(input int i);
    return 64'(bus.bullet_x[10*i +: 10]);
  endfunction

  function automatic logic [63:0] yv(input int i);
    return 64'(bus.bullet_y[10*i +: 10]);
  endfunction

  function automatic logic [63:0] hc();
    return 64'(bus.hit_count);
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.tick = 1'b0;
    bus.enable = 1'b1;
    bus.fire = 1'b1;
    bus.reimux = 10'd320;
    bus.reimuy = 10'd400;
    bus.bossx = 10'd320;
    bus.bossy = 10'd100;
    bus.boss_vuln = 1'b0;

    repeat (4) step(1'b1);
    chk("rst_valid", vld(), 0);
    chk("rst_x", 64'(bus.bullet_x), 0);
    chk("rst_y", 64'(bus.bullet_y), 0);
    chk("rst_cnt", hc(), 0);
    chk("rst_full", 64'(bus.pool_full), 0);
    chk("rst_pulse", 64'(bus.hit_pulse), 0);
    rst = 1'b1;
    repeat (2) step(1'b0);
    chk("rel_valid", vld(), 0);
    chk("rel_y", 64'(bus.bullet_y), 0);

    // spawn and move
    step(1'b1);
    chk("sp_valid", vld(), 1);
    chk("sp_x0", xv(0), 320);
    chk("sp_y0", yv(0), 384);
    bus.fire = 1'b0;
    step(1'b1);
    chk("mv_y0", yv(0), 376);
    chk("mv_valid", vld(), 1);
    clear_pool();
    chk("clr1_valid", vld(), 0);

    // no boss: bullet exits at the top
    bus.fire = 1'b1;
    step(1'b1);
    bus.fire = 1'b0;
    repeat (48) step(1'b1);
    chk("top_valid", vld(), 1);
    chk("top_y0", yv(0), 0);
    step(1'b1);
    chk("top_gone", vld(), 0);
    chk("top_pulse", 64'(bus.hit_pulse), 0);
    chk("top_cnt", hc(), 0);

    // vulnerable boss at (320,100): hit when ny=128
    bus.boss_vuln = 1'b1;
    bus.fire = 1'b1;
    step(1'b1);
    bus.fire = 1'b0;
    repeat (31) step(1'b1);
    chk("pre_valid", vld(), 1);
    chk("pre_y0", yv(0), 136);
    chk("pre_pulse", 64'(bus.hit_pulse), 0);
    step(1'b1);
    chk("hit_valid", vld(), 0);
    chk("hit_pulse", 64'(bus.hit_pulse), 1);
    chk("hit_cnt", hc(), 1);
    chk("hit_y0", yv(0), 0);
    step(1'b0);
    chk("hit_pulse_off", 64'(bus.hit_pulse), 0);
    chk("hit_cnt_hold", hc(), 1);
    bus.boss_vuln = 1'b0;

    // cooldown and fill
    bus.fire = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      step(1'b1);
      if (t == 3) chk("cd_t3", vld(), 1);
      if (t == 4) chk("cd_t4", vld(), 3);
      if (t == 12) begin
        chk("full_t12", 64'(bus.pool_full), 1);
        chk("fill_t12", vld(), 15);
      end
      if (t == 16) begin
        chk("fill_t16", vld(), 15);
        chk("y0_t16", yv(0), 256);
        chk("y3_t16", yv(3), 352);
      end
    end
    clear_pool();
    chk("clr2_valid", vld(), 0);
    chk("clr2_full", 64'(bus.pool_full), 0);

    // top exit with full pool: freed slot reused next tick
    bus.fire = 1'b1;
    bus.reimuy = 10'd400;
    repeat (12) step(1'b1);
    chk("re_t11", vld(), 7);
    bus.reimuy = 10'd44;
    step(1'b1);
    chk("re_y3", yv(3), 28);
    repeat (3) step(1'b1);
    chk("re_y3_low", yv(3), 4);
    chk("re_full", vld(), 15);
    step(1'b1);
    chk("re_exit", vld(), 7);
    chk("re_pulse", 64'(bus.hit_pulse), 0);
    step(1'b1);
    chk("re_reuse", vld(), 15);
    chk("re_y3_new", yv(3), 28);
    chk("re_cnt", hc(), 1);
    clear_pool();

    // spawn y saturates at 0
    bus.reimuy = 10'd10;
    bus.fire = 1'b1;
    step(1'b1);
    chk("sat_valid", vld(), 1);
    chk("sat_y0", yv(0), 0);
    clear_pool();

    // enable clear, then async reset mid-flight
    bus.reimuy = 10'd400;
    bus.fire = 1'b1;
    repeat (9) step(1'b1);
    chk("mid_valid", vld(), 7);
    bus.fire = 1'b0;
    bus.enable = 1'b0;
    step(1'b0);
    chk("en_valid", vld(), 0);
    chk("en_y", 64'(bus.bullet_y), 0);
    chk("en_cnt", hc(), 1);
    bus.enable = 1'b1;
    bus.fire = 1'b1;
    step(1'b1);
    chk("en_spawn", vld(), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", vld(), 0);
    chk("ar_x", 64'(bus.bullet_x), 0);
    chk("ar_cnt", hc(), 0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reimu_bullet_pool.md
Name: reimu_bullet_pool

Overview:
- Parametrised successor to the single-shot player bullet block: manages a pool of N_BULLETS independent player bullets.
- Spawns at the player sprite while the shoot key is held, rate-limited by a cooldown.
- Moves all live bullets up once per movement tick and retires them at screen top or on a boss-hitbox collision.
- Feeds packed positions/valid flags to the RGB renderer and hit events to boss HP logic.

Parameters:
- N_BULLETS, 4, pool size (1..16).
- STEP, 8, pixels moved up per tick.
- COOLDOWN, 3, ticks blocked after each spawn.
- SPAWN_YOFF, 16, spawn y offset above player y.
- BOSS_HW, 32, boss hitbox half-width.
- BOSS_HH, 32, boss hitbox half-height.
- CNT_W, 8, hit counter width.

Ports:
- clk  in  1  system clock; all logic in this single domain.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle movement-enable pulse, generated by the caller in clk domain.
- enable  in  1  game running; low clears the pool.
- fire  in  1  shoot key level.
- reimux  in  10  player x.
- reimuy  in  10  player y.
- bossx  in  10  boss centre x.
- bossy  in  10  boss centre y.
- boss_vuln  in  1  boss hitbox active.
- bullet_x  out  10*N_BULLETS  packed x, slot i at [10i+9:10i].
- bullet_y  out  10*N_BULLETS  packed y.
- bullet_valid  out  N_BULLETS  slot live.
- pool_full  out  1  all slots live.
- hit_pulse  out  1  one-cycle pulse, at least one hit this tick.
- hit_count  out  CNT_W  saturating total hits.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0, all outputs and internal state are 0, including cooldown.
- All state updates only in cycles with tick=1 (exceptions: enable clear, hit_pulse deassert). Registered outputs change the cycle after tick.
- Per tick, for each live slot, evaluated in order:
  1. Exit: if y < STEP, clear valid; no hit.
  2. Move: otherwise ny = y - STEP.
  3. Hit: if boss_vuln and |x-bossx| < BOSS_HW and |ny-bossy| < BOSS_HH, clear valid and count a hit. Comparison uses 11-bit signed differences.
- Spawn, same tick, after move/hit:
  - Condition: fire=1 and cooldown=0 and a free slot exists.
  - A free slot is one not live before this tick; slots freed in this tick are not reusable until the next tick.
  - Lowest free index is selected.
  - Loads x=reimux, y = reimuy-SPAWN_YOFF, saturating at 0.
  - Loads cooldown=COOLDOWN.
  - The new bullet is neither moved nor hit-checked in its spawn tick.
- Cooldown: on a tick with cooldown>0, decrement; no spawn that tick. Holding fire spawns every COOLDOWN+1 ticks.
- Full pool: fire ignored and cooldown not loaded; pool_full=1 whenever all valid bits are 1.
- hit_pulse: 1 for exactly the clk cycle after a tick with ≥1 hit; 0 otherwise.
- hit_count: adds the popcount of hits in the tick, saturating at 2^CNT_W-1.
- enable=0: on the next clk edge, regardless of tick:
  - all valid, x, y and cooldown cleared;
  - hit_count held; hit_pulse forced 0.
  - Spawn blocked while enable=0.
- Invalid slots drive x=0, y=0.

Decomposition:
- Package bullet_pkg: COORD_W=10, SCREEN_W=640, SCREEN_H=480, and a slot record typedef (valid, x, y).
- One sub-module, bullet_slot: holds one bullet's registers, move/exit/hit compare, load port; outputs hit and free.
- Top-level contents: N_BULLETS bullet_slot instances via generate, plus the lowest-free priority encoder, cooldown counter, popcount/saturating hit counter, and output packing.

Test Plan:
- Reset: drive rst=0 with fire=1 and tick toggling -> bullet_valid=0, all x/y=0, hit_count=0, pool_full=0. After release with no tick, outputs unchanged.
- Spawn and move: reimux=320, reimuy=400, one tick with fire=1 -> slot0 valid, x=320, y=384. Next tick with fire=0 -> y=376; other slots invalid.
- Cooldown and fill: fire held every tick, boss_vuln=0 -> spawns at ticks 0,4,8,12 into slots 0..3. pool_full=1 after tick 12. Tick 16 spawns nothing. Slot0 y=384-8*16=256 at tick 16.
- Hit: boss at (320,100), boss_vuln=1, single bullet spawned at y=384 -> retires on the 32nd tick after spawn (ny=128). hit_pulse high exactly one cycle, hit_count=1. With boss_vuln=0 the same bullet exits at top instead, with hit_count=0.
- Top exit and slot reuse: bullet at y=4, tick -> valid cleared, no hit_pulse. Same tick with fire and cooldown=0 does not reuse that slot if no other slot is free; reuse happens on the next tick.
- Clear/reset mid-flight: 3 live bullets, enable=0 for one cycle (no tick) -> all cleared next edge, hit_count held. Then rst=0 asserted between ticks -> immediate clear without clk edge, hit_count=0.
